// File: rtl/hsi_tx_pkg.sv
// Shared definitions for the slave-side HSI transmit path.
//   tx_state_e   : frame sequencer states of hsi_s_tx_arbiter
//   CRC16_*      : CRC16-CCITT polynomial and seed used for frame trailers
//   FLAG_*       : frame flag bytes common to the tx and rx sides
package hsi_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StCrcHi,
    StCrcLo,
    StGap
  } tx_state_e;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam logic [7:0] FLAG_ACK    = 8'h06;
  localparam logic [7:0] FLAG_NACK   = 8'h15;
  localparam logic [7:0] FLAG_STATUS = 8'h5A;

endpackage

// File: rtl/hsi_crc16_byte.sv
// One-byte CRC16-CCITT update: MSB-first, no reflection, no final XOR.
//   crc_in  : running CRC before this byte
//   d       : data byte
//   crc_out : running CRC after this byte
module hsi_crc16_byte
  import hsi_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  d,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[15] ? ((crc_out << 1) ^ CRC16_POLY) : (crc_out << 1);
    end
  end

endmodule

// File: rtl/hsi_s_tx_arbiter.sv
// Round-robin arbiter and frame sequencer in front of the slave-side serial coder.
// A grant is locked for a whole frame; bytes are forwarded one per coder busy period,
// followed by a CRC16 trailer and a minimum idle gap. A stalled source is aborted.
//   clk, n_rst       : clock, asynchronous active-low reset
//   clk_en           : bit-rate enable, drives the inter-frame gap counter only
//   req              : per-source frame request (level)
//   src_d            : source bytes, source i at [8i+7:8i]
//   src_d_rdy        : per-source byte valid
//   src_last         : byte is the last of its frame
//   src_ack          : one-clk pulse, byte consumed
//   grant/active_id  : one-hot grant and its index
//   cd_d, cd_d_rdy   : byte and load strobe to the coder
//   cd_busy          : coder serialising
//   frame_done       : pulse after CRC low byte has been serialised
//   frame_abort      : pulse on source stall timeout
module hsi_s_tx_arbiter
  import hsi_tx_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned GAP_TICKS   = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clk_en,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] src_d,
  input  logic [N_REQ-1:0]   src_d_rdy,
  input  logic [N_REQ-1:0]   src_last,
  output logic [N_REQ-1:0]   src_ack,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         cd_d,
  output logic               cd_d_rdy,
  input  logic               cd_busy,
  output logic               frame_done,
  output logic               frame_abort,
  output logic [2:0]         active_id
);

  tx_state_e        state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, src_ack_q, src_ack_d;
  logic [2:0]       active_id_q, active_id_d, rr_ptr_q, rr_ptr_d;
  logic [15:0]      crc_q, crc_d, crc_next, to_cnt_q, to_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d, cd_d_q, cd_d_d;
  logic             cd_d_rdy_q, cd_d_rdy_d, wait_q, wait_d, lo_sent_q, lo_sent_d;
  logic             frame_done_q, frame_done_d, frame_abort_q, frame_abort_d;

  logic             slot_free, rdy_g, last_g, found;
  logic [7:0]       byte_g;
  logic [2:0]       win;

  // Granted source's signals, selected by the one-hot grant.
  always_comb begin
    rdy_g  = |(src_d_rdy & grant_q);
    last_g = |(src_last & grant_q);
    byte_g = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) byte_g = byte_g | src_d[8*i +: 8];
    end
  end

  // Round-robin search: priority k is source (rr_ptr + k) mod N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && req[i] &&
            ((i == rr_ptr_q + k) || (i + N_REQ == rr_ptr_q + k))) begin
          found = 1'b1;
          win   = 3'(i);
        end
      end
    end
  end

  hsi_crc16_byte u_crc (
    .crc_in  (crc_q),
    .d       (byte_g),
    .crc_out (crc_next)
  );

  // Wait flag blocks a second strobe until the coder has shown busy for the first.
  assign slot_free = !cd_busy && !wait_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    active_id_d   = active_id_q;
    rr_ptr_d      = rr_ptr_q;
    crc_d         = crc_q;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    cd_d_d        = cd_d_q;
    cd_d_rdy_d    = 1'b0;
    src_ack_d     = '0;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    lo_sent_d     = lo_sent_q;
    wait_d        = cd_busy ? 1'b0 : wait_q;

    case (state_q)
      StIdle: begin
        if (found) begin
          state_d     = StData;
          grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          active_id_d = win;
          rr_ptr_d    = (win == 3'(N_REQ - 1)) ? 3'd0 : win + 3'd1;
          crc_d       = CRC16_INIT;
          to_cnt_d    = '0;
        end
      end
      StData: begin
        if (slot_free) begin
          if (rdy_g) begin
            // A byte always beats a coincident timeout.
            cd_d_d     = byte_g;
            cd_d_rdy_d = 1'b1;
            wait_d     = 1'b1;
            src_ack_d  = grant_q;
            crc_d      = crc_next;
            to_cnt_d   = '0;
            if (last_g) state_d = StCrcHi;
          end else if (to_cnt_q == 16'(TIMEOUT_CYC - 1)) begin
            frame_abort_d = 1'b1;
            grant_d       = '0;
            gap_cnt_d     = '0;
            state_d       = StGap;
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
        end
      end
      StCrcHi: begin
        if (slot_free) begin
          cd_d_d     = crc_q[15:8];
          cd_d_rdy_d = 1'b1;
          wait_d     = 1'b1;
          lo_sent_d  = 1'b0;
          state_d    = StCrcLo;
        end
      end
      StCrcLo: begin
        if (slot_free) begin
          if (!lo_sent_q) begin
            cd_d_d     = crc_q[7:0];
            cd_d_rdy_d = 1'b1;
            wait_d     = 1'b1;
            lo_sent_d  = 1'b1;
          end else begin
            // Low byte strobed and coder idle again: frame is complete.
            frame_done_d = 1'b1;
            grant_d      = '0;
            gap_cnt_d    = '0;
            lo_sent_d    = 1'b0;
            state_d      = StGap;
          end
        end
      end
      StGap: begin
        if (clk_en && !cd_busy) begin
          if (gap_cnt_q == 8'(GAP_TICKS - 1)) state_d = StIdle;
          else gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      active_id_q   <= '0;
      rr_ptr_q      <= '0;
      crc_q         <= CRC16_INIT;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      cd_d_q        <= '0;
      cd_d_rdy_q    <= 1'b0;
      src_ack_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      wait_q        <= 1'b0;
      lo_sent_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      active_id_q   <= active_id_d;
      rr_ptr_q      <= rr_ptr_d;
      crc_q         <= crc_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      cd_d_q        <= cd_d_d;
      cd_d_rdy_q    <= cd_d_rdy_d;
      src_ack_q     <= src_ack_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      wait_q        <= wait_d;
      lo_sent_q     <= lo_sent_d;
    end
  end

  assign grant       = grant_q;
  assign active_id   = active_id_q;
  assign src_ack     = src_ack_q;
  assign cd_d        = cd_d_q;
  assign cd_d_rdy    = cd_d_rdy_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_hsi_s_tx_arbiter.sv
// Directed bench for hsi_s_tx_arbiter with a byte-source model per requester and a
// simple coder model that stays busy for three cycles per loaded byte.
module tb_hsi_s_tx_arbiter;

  localparam int N = 3;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic           clk_en = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] src_d;
  logic [N-1:0]   src_d_rdy, src_last, src_ack, grant;
  logic [7:0]     cd_d;
  logic           cd_d_rdy, cd_busy, frame_done, frame_abort;
  logic [2:0]     active_id;
  logic           busy_hold = 1'b0;

  hsi_s_tx_arbiter #(
    .N_REQ       (N),
    .GAP_TICKS   (16),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .clk_en      (clk_en),
    .req         (req),
    .src_d       (src_d),
    .src_d_rdy   (src_d_rdy),
    .src_last    (src_last),
    .src_ack     (src_ack),
    .grant       (grant),
    .cd_d        (cd_d),
    .cd_d_rdy    (cd_d_rdy),
    .cd_busy     (cd_busy),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .active_id   (active_id)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 clk_en = ~clk_en;
    end
  end

  // Source model: byte index = acks seen since the source was (re)loaded.
  logic [7:0] mem   [N][16];
  logic       lastm [N][16];
  int         len [N];
  int         avail [N];
  int         base [N];
  int         ack_cnt [N];

  always_comb begin
    src_d     = '0;
    src_d_rdy = '0;
    src_last  = '0;
    for (int i = 0; i < N; i++) begin
      if ((ack_cnt[i] - base[i] < len[i]) && (ack_cnt[i] - base[i] < avail[i])) begin
        src_d_rdy[i]    = 1'b1;
        src_d[8*i +: 8] = mem[i][ack_cnt[i] - base[i]];
        src_last[i]     = lastm[i][ack_cnt[i] - base[i]];
      end
    end
  end

  // Coder model and monitors.
  logic [7:0]   clog [256];
  int           clog_n = 0, busy_cnt = 0, cyc = 0, strobe_cyc = 0, abort_cyc = 0;
  int           done_n = 0, abort_n = 0, gap_ticks = 0, gl_n = 0, onehot_viol = 0;
  int           glog [16];
  int           gapl [16];
  logic [N-1:0] prev_grant = '0;

  assign cd_busy = (busy_cnt != 0) || busy_hold;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) if (src_ack[i]) ack_cnt[i] <= ack_cnt[i] + 1;
    if (cd_d_rdy) begin
      if (clog_n < 256) clog[clog_n] <= cd_d;
      clog_n     <= clog_n + 1;
      busy_cnt   <= 3;
      strobe_cyc <= cyc;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (frame_done) begin
      done_n    <= done_n + 1;
      gap_ticks <= clk_en ? 1 : 0;
    end else if (clk_en) begin
      gap_ticks <= gap_ticks + 1;
    end
    if (frame_abort) begin
      abort_n   <= abort_n + 1;
      abort_cyc <= cyc;
    end
    if (grant != 0 && prev_grant == 0 && gl_n < 16) begin
      glog[gl_n] <= int'(active_id);
      gapl[gl_n] <= gap_ticks + (clk_en ? 1 : 0);
      gl_n       <= gl_n + 1;
    end
    prev_grant <= grant;
    if ($countones(grant) > 1) onehot_viol <= onehot_viol + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] digits [9];
  logic [7:0] exp_s  [28];

  initial begin
    int n, c0, d0, a0, k;
    for (int i = 0; i < 9; i++) digits[i] = 8'h31 + 8'(i);
    for (int i = 0; i < N; i++) begin
      len[i] = 0; avail[i] = 0; base[i] = 0;
      for (int j = 0; j < 16; j++) begin
        mem[i][j] = 8'h00; lastm[i][j] = 1'b0;
      end
    end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_active_id", active_id, 0);
    check_eq("rst_cd_d_rdy", cd_d_rdy, 0);
    check_eq("rst_cd_d", cd_d, 0);
    check_eq("rst_src_ack", src_ack, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_frame_abort", frame_abort, 0);
    n_rst = 1'b1;

    // Round robin with all requesters: src0 "123456789" then 0x00, src1 0x00,
    // src2 "123456789".
    for (int i = 0; i < 9; i++) begin
      mem[0][i] = digits[i];
      mem[2][i] = digits[i];
    end
    mem[0][9] = 8'h00; lastm[0][8] = 1'b1; lastm[0][9] = 1'b1;
    len[0] = 10; avail[0] = 10;
    mem[1][0] = 8'h00; lastm[1][0] = 1'b1; len[1] = 1; avail[1] = 1;
    lastm[2][8] = 1'b1; len[2] = 9; avail[2] = 9;
    k = 0;
    for (int i = 0; i < 9; i++) exp_s[k++] = digits[i];
    exp_s[k++] = 8'h29; exp_s[k++] = 8'hB1;
    exp_s[k++] = 8'h00; exp_s[k++] = 8'hE1; exp_s[k++] = 8'hF0;
    for (int i = 0; i < 9; i++) exp_s[k++] = digits[i];
    exp_s[k++] = 8'h29; exp_s[k++] = 8'hB1;
    exp_s[k++] = 8'h00; exp_s[k++] = 8'hE1; exp_s[k++] = 8'hF0;
    req = 3'b111;

    // Coder held busy for 100 cycles mid-frame
    n = 0;
    while (clog_n < 4 && n < 500) begin @(negedge clk); n++; end
    check_eq("hold_reach", clog_n, 4);
    busy_hold = 1'b1;
    c0 = clog_n; a0 = abort_n;
    repeat (100) @(negedge clk);
    check_eq("hold_no_strobe", clog_n, c0);
    check_eq("hold_no_abort", abort_n, a0);
    busy_hold = 1'b0;

    n = 0;
    while (done_n < 4 && n < 6000) begin @(negedge clk); n++; end
    req = 3'b000;
    check_eq("rr_done_count", done_n, 4);
    check_eq("rr_byte_count", clog_n, 28);
    for (int i = 0; i < 28; i++) check_eq($sformatf("rr_byte%0d", i), clog[i], exp_s[i]);
    check_eq("rr_grant0", glog[0], 0);
    check_eq("rr_grant1", glog[1], 1);
    check_eq("rr_grant2", glog[2], 2);
    check_eq("rr_grant3", glog[3], 0);
    check_eq("gap_ticks1", gapl[1], 17);
    check_eq("gap_ticks2", gapl[2], 17);
    check_eq("gap_ticks3", gapl[3], 17);
    check_eq("onehot", onehot_viol, 0);
    check_eq("acks_src0", ack_cnt[0], 10);
    check_eq("acks_src1", ack_cnt[1], 1);
    check_eq("acks_src2", ack_cnt[2], 9);
    check_eq("rr_no_abort", abort_n, 0);
    repeat (60) @(negedge clk);
    check_eq("idle_grant", grant, 0);

    // Source 1 stalls after two bytes
    base[1] = ack_cnt[1];
    for (int j = 0; j < 5; j++) begin mem[1][j] = 8'hA0 + 8'(j); lastm[1][j] = 1'b0; end
    len[1] = 5; avail[1] = 2;
    c0 = clog_n; d0 = done_n; a0 = abort_n;
    req = 3'b010;
    n = 0;
    while (abort_n == a0 && n < 500) begin @(negedge clk); n++; end
    req = 3'b000;
    check_eq("stall_abort", abort_n - a0, 1);
    check_eq("stall_bytes", clog_n - c0, 2);
    check_eq("stall_byte0", clog[c0], 8'hA0);
    check_eq("stall_byte1", clog[c0+1], 8'hA1);
    check_eq("stall_no_done", done_n, d0);
    check_eq("stall_latency", abort_cyc - strobe_cyc, 20);
    check_eq("stall_grant", grant, 0);
    repeat (60) @(negedge clk);
    check_eq("stall_no_crc", clog_n - c0, 2);

    // Reset while waiting to send the CRC high byte
    base[1] = ack_cnt[1];
    mem[1][0] = 8'h55; lastm[1][0] = 1'b1; len[1] = 1; avail[1] = 1;
    c0 = clog_n; d0 = done_n;
    req = 3'b010;
    n = 0;
    while (clog_n == c0 && n < 200) begin @(negedge clk); n++; end
    check_eq("mid_byte", clog[c0], 8'h55);
    n_rst = 1'b0;
    #1;
    check_eq("mid_rst_grant", grant, 0);
    check_eq("mid_rst_active_id", active_id, 0);
    check_eq("mid_rst_cd_d", cd_d, 0);
    check_eq("mid_rst_cd_d_rdy", cd_d_rdy, 0);
    check_eq("mid_rst_src_ack", src_ack, 0);
    check_eq("mid_rst_done", frame_done, 0);
    check_eq("mid_rst_abort", frame_abort, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    req = 3'b111;
    n = 0;
    while (grant == 0 && n < 50) begin @(negedge clk); n++; end
    check_eq("regrant_grant", grant, 3'b001);
    check_eq("regrant_id", active_id, 0);
    check_eq("mid_no_done", done_n, d0);
    req = 3'b000;
    repeat (80) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hsi_s_tx_arbiter.md
Name: hsi_s_tx_arbiter

Overview:
Round-robin arbiter and frame sequencer that shares the single slave-side serial coder among N_REQ byte-stream requesters, e.g. the status responder, the data-packet responder and the error/NACK responder. It locks a grant for a whole frame and forwards bytes to the coder under a per-byte handshake. It appends a CRC16-CCITT trailer and enforces a minimum inter-frame gap. A stalled source is aborted by timeout.

Parameters:
N_REQ, 3, number of requesters (2..8)
GAP_TICKS, 16, minimum idle clk_en ticks between frames (1..255)
TIMEOUT_CYC, 4096, clk cycles a granted source may stall before abort (16..65535)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
clk_en  in  1  bit-rate enable; used only by the gap counter
req  in  N_REQ  per-source frame request (level)
src_d  in  8*N_REQ  source bytes; source i occupies bits [8i+7:8i]
src_d_rdy  in  N_REQ  source i byte valid
src_last  in  N_REQ  qualifies src_d_rdy: the byte is the last of the frame
src_ack  out  N_REQ  one-clk pulse: byte consumed
grant  out  N_REQ  one-hot; held for the whole frame including CRC
cd_d  out  8  byte to coder
cd_d_rdy  out  1  one-clk load strobe to coder
cd_busy  in  1  coder serialising
frame_done  out  1  one-clk pulse after the CRC low byte completes
frame_abort  out  1  one-clk pulse on timeout
active_id  out  3  index of the granted source; valid while grant!=0

Behaviour:
- Clock and reset: clk, with n_rst as an asynchronous, active-low reset.
- Reset values: state=IDLE, grant=0, src_ack=0, cd_d=0, cd_d_rdy=0, frame_done=0, frame_abort=0, active_id=0, rr_ptr=0, crc=16'hFFFF. Reset mid-frame drops the frame silently; no done or abort pulse is generated.
- States: IDLE, DATA, CRC_HI, CRC_LO, GAP.
- IDLE: the first set req bit searching upward from rr_ptr, wrapping, is granted. Next cycle: state goes to DATA, grant and active_id are set, crc=16'hFFFF, rr_ptr=winner+1 mod N_REQ. Requests arriving later, or deasserting req, do not affect a locked grant.
- Coder handshake: a "slot" is free when cd_busy=0 and the wait flag is clear. Issuing cd_d_rdy sets the wait flag. The flag clears on the first cycle in which cd_busy=1 is seen. One byte per busy period; never two strobes without an intervening cd_busy high.
- DATA, per byte: when the slot is free and src_d_rdy[g]=1, in the same cycle latch cd_d=src_d[g], pulse cd_d_rdy, pulse src_ack[g] and update crc. Latency from src_d_rdy to cd_d_rdy is 1 clk.
- DATA, end: if src_last[g] was set with the byte, go to CRC_HI.
- CRC: polynomial 0x1021, MSB-first, no reflection, no final XOR. It updates only on data bytes, never on CRC bytes.
- CRC_HI: on the next free slot send crc[15:8], then go to CRC_LO.
- CRC_LO: on the next free slot send crc[7:0]. Then wait for cd_busy to fall, pulse frame_done, clear grant and go to GAP.
- Timeout: a counter runs in DATA while src_d_rdy[g]=0 and the slot is free, and is cleared on every consumed byte. Reaching TIMEOUT_CYC-1 pulses frame_abort, clears grant, sends no CRC and goes to GAP. Any byte already in the coder completes normally.
- GAP: counts clk_en ticks after cd_busy=0. At GAP_TICKS go to IDLE. req is ignored during GAP.
- Simultaneous events:
  - src_last and a timeout in the same cycle: the byte wins and the timeout counter clears.
  - Several req bits at once: round-robin from rr_ptr.
  - A single requester holding req: re-granted after every GAP.

Decomposition:
- Shared package hsi_tx_pkg holds:
  - state encodings;
  - CRC16_POLY=16'h1021 and CRC16_INIT=16'hFFFF;
  - the FLAG_* constants already shared with the rx side.
- Sub-module hsi_crc16_byte: combinational, takes crc_in[15:0] and d[7:0], returns crc_out[15:0] (8 unrolled steps).
- Everything else stays in the top level.

Test Plan:
- Grant 0, bytes "123456789" (0x31..0x39, last on 0x39) -> coder receives the 9 bytes then 0x29, 0xB1; then frame_done, grant=0, and ≥16 clk_en ticks before the next grant.
- req=3'b111 held continuously -> grants in order 0,1,2,0; each frame's CRC is correct and grant stays one-hot throughout.
- Grant 1, single byte 0x00 with last -> coder receives 0x00, 0xE1, 0xF0; src_ack[1] pulses exactly once.
- Source stalls after 2 bytes, TIMEOUT_CYC=16 -> frame_abort after 16 stalled cycles; no CRC bytes are sent and no frame_done.
- cd_busy held high 100 cycles mid-frame -> no cd_d_rdy strobe and no timeout increment; resumes correctly when cd_busy falls.
- n_rst pulsed during CRC_HI -> all outputs return to reset values immediately; a new req is granted from index 0.
